// File: rtl/pwm_fade_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_fade_pkg
// Description : Shared types, default widths and the saturating step helper
//               used by the PWM fade controller and its prescaler.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_fade_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } fade_state_t;

    localparam int c_BIT_WIDTH = 8;
    localparam int c_RATE_W    = 16;
    // Working width of sat_step; callers zero-extend into it and truncate back.
    localparam int c_SAT_W     = 32;

    // Move cur toward tgt by at most step. The gap is taken one bit wider
    // than the operands so the comparison can never wrap, which guarantees
    // the result lands on tgt instead of overshooting it.
    function automatic logic [c_SAT_W-1:0] sat_step(
        input logic [c_SAT_W-1:0] cur,
        input logic [c_SAT_W-1:0] tgt,
        input logic [c_SAT_W-1:0] step
    );
        logic [c_SAT_W:0] gap;
        logic [c_SAT_W:0] stp;
        stp = {1'b0, step};
        if (tgt >= cur) begin
            gap      = {1'b0, tgt} - {1'b0, cur};
            sat_step = (gap <= stp) ? tgt : (cur + step);
        end else begin
            gap      = {1'b0, cur} - {1'b0, tgt};
            sat_step = (gap <= stp) ? tgt : (cur - step);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_fade_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_fade_if
// Description : Fade-request channel (valid/ready plus target duty, step and
//               rate). master = requester, slave = fade controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_fade_if #(
    parameter int BIT_WIDTH = 8,
    parameter int RATE_W    = 16
);
    logic                 tgt_valid;
    logic                 tgt_ready;
    logic [BIT_WIDTH-1:0] tgt_duty;
    logic [BIT_WIDTH-1:0] tgt_step;
    logic [RATE_W-1:0]    tgt_rate;

    modport master (
        output tgt_valid, tgt_duty, tgt_step, tgt_rate,
        input  tgt_ready
    );

    modport slave (
        input  tgt_valid, tgt_duty, tgt_step, tgt_rate,
        output tgt_ready
    );
endinterface
`default_nettype wire

// File: rtl/pwm_fade_tick.sv
`default_nettype none
// ============================================================================
// Module      : pwm_fade_tick
// Description : Programmable prescaler. tick is high while cnt == rate, so a
//               tick occurs once every rate+1 enabled clocks.
// Ports       : clk, rst_n (async, active low)
//               clr  - force count to zero (wins over en)
//               en   - advance the count this clock
//               rate - terminal count
//               tick - count has reached rate
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_fade_tick #(
    parameter int RATE_W = 16
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              clr,
    input  wire logic              en,
    input  wire logic [RATE_W-1:0] rate,
    output      logic              tick
);

    logic [RATE_W-1:0] cnt_q;
    logic [RATE_W-1:0] cnt_d;

    assign tick = (cnt_q == rate);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : (cnt_q + 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_fade_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwm_fade_ctrl
// Description : Accepts a target duty over a valid/ready channel and ramps the
//               registered duty output toward it in saturating steps, one step
//               every rate+1 un-frozen clocks. Drives pwm_module duty/max_value.
// Ports       : clk, rst_n (async, active low)
//               tgt       - request channel (slave side)
//               freeze    - hold duty and prescaler
//               duty      - current duty (registered)
//               max_value - constant MAX_VALUE
//               busy      - ramp in progress
//               done      - one-cycle pulse on request completion
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_fade_ctrl
    import pwm_fade_pkg::*;
#(
    parameter int                   BIT_WIDTH = c_BIT_WIDTH,
    parameter int                   RATE_W    = c_RATE_W,
    parameter logic [BIT_WIDTH-1:0] MAX_VALUE = {BIT_WIDTH{1'b1}}
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    pwm_fade_if.slave                 tgt,
    input  wire logic                 freeze,
    output      logic [BIT_WIDTH-1:0] duty,
    output      logic [BIT_WIDTH-1:0] max_value,
    output      logic                 busy,
    output      logic                 done
);

    fade_state_t          state_q,  state_d;
    logic [BIT_WIDTH-1:0] duty_q,   duty_d;
    logic [BIT_WIDTH-1:0] target_q, target_d;
    logic [BIT_WIDTH-1:0] step_q,   step_d;
    logic [RATE_W-1:0]    rate_q,   rate_d;
    logic                 done_q,   done_d;

    logic                 w_accept;
    logic                 w_run;
    logic                 w_tick;
    logic [BIT_WIDTH-1:0] w_tgt_clamp;
    logic [BIT_WIDTH-1:0] w_step_fix;
    logic [BIT_WIDTH-1:0] w_next_duty;

    assign tgt.tgt_ready = (state_q == IDLE);
    assign busy          = (state_q == RAMP);
    assign duty          = duty_q;
    assign done          = done_q;
    assign max_value     = MAX_VALUE;

    assign w_accept    = tgt.tgt_valid && (state_q == IDLE);
    assign w_tgt_clamp = (tgt.tgt_duty > MAX_VALUE) ? MAX_VALUE : tgt.tgt_duty;
    assign w_step_fix  = (tgt.tgt_step == '0) ? BIT_WIDTH'(1) : tgt.tgt_step;

    // Frozen edges must not advance the prescaler, so freeze gates its enable.
    assign w_run = (state_q == RAMP) && !freeze;

    assign w_next_duty = BIT_WIDTH'(sat_step(c_SAT_W'(duty_q),
                                             c_SAT_W'(target_q),
                                             c_SAT_W'(step_q)));

    pwm_fade_tick #(
        .RATE_W (RATE_W)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_accept),
        .en    (w_run),
        .rate  (rate_q),
        .tick  (w_tick)
    );

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        step_d   = step_q;
        rate_d   = rate_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    target_d = w_tgt_clamp;
                    step_d   = w_step_fix;
                    rate_d   = tgt.tgt_rate;
                    // Already at the target: complete without ramping.
                    if (w_tgt_clamp == duty_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RAMP;
                    end
                end
            end
            RAMP: begin
                if (w_run && w_tick) begin
                    duty_d = w_next_duty;
                    if (w_next_duty == target_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            duty_q   <= '0;
            target_q <= '0;
            step_q   <= '0;
            rate_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            step_q   <= step_d;
            rate_q   <= rate_d;
            done_q   <= done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_fade_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_fade_ctrl
// Description : Scoreboard bench for pwm_fade_ctrl. Two instances: one with
//               full-scale 8'hFF, one with MAX_VALUE = 200.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_fade_ctrl;

    typedef struct {
        int inst;
        int cyc;
        int duty;
    } exp_t;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       freeze = 1'b0;
    logic [7:0] duty_a, duty_b, max_a, max_b;
    logic       busy_a, busy_b, done_a, done_b;

    int   cyc     = 0;
    int   n_chk   = 0;
    int   n_pass  = 0;
    int   m_duty [2];
    int   prev   [2];
    exp_t step_q [$];
    exp_t done_q [$];

    pwm_fade_if #(.BIT_WIDTH(8), .RATE_W(16)) if_a ();
    pwm_fade_if #(.BIT_WIDTH(8), .RATE_W(16)) if_b ();

    pwm_fade_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .tgt(if_a.slave), .freeze(freeze),
        .duty(duty_a), .max_value(max_a), .busy(busy_a), .done(done_a)
    );

    pwm_fade_ctrl #(.MAX_VALUE(8'd200)) dut_b (
        .clk(clk), .rst_n(rst_n), .tgt(if_b.slave), .freeze(freeze),
        .duty(duty_b), .max_value(max_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic int mon_duty(input int i);
        return (i == 0) ? int'(duty_a) : int'(duty_b);
    endfunction

    // Scoreboard: every duty change and every done pulse pops one entry.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                prev[i] = mon_duty(i);
            end else begin
                if (mon_duty(i) != prev[i]) begin
                    if (step_q.size() == 0) begin
                        chk("unexpected_step", mon_duty(i), prev[i]);
                    end else begin
                        exp_t e;
                        e = step_q.pop_front();
                        chk("step_inst",  i,           e.inst);
                        chk("step_duty",  mon_duty(i), e.duty);
                        chk("step_cycle", cyc,         e.cyc);
                        chk("duty_le_max", int'(mon_duty(i) <= ((i == 0) ? int'(max_a) : int'(max_b))), 1);
                    end
                    prev[i] = mon_duty(i);
                end
                if ((i == 0) ? done_a : done_b) begin
                    if (done_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        exp_t e;
                        e = done_q.pop_front();
                        chk("done_inst",  i,   e.inst);
                        chk("done_cycle", cyc, e.cyc);
                        chk("done_ready", int'((i == 0) ? if_a.tgt_ready : if_b.tgt_ready), 1);
                    end
                end
            end
        end
    end

    // Drive one request at the current negedge and push its expected steps.
    // frz_k > 0 means a 7-clock freeze follows step frz_k.
    task automatic send(input int inst, input int t, input int s, input int r,
                        input int frz_k, output int n_acc);
        int   mx, tc, sc, d, k, nd;
        exp_t e;
        n_acc = cyc + 1;
        mx = (inst == 0) ? 255 : 200;
        tc = (t > mx) ? mx : t;
        sc = (s == 0) ? 1 : s;
        d  = m_duty[inst];
        k  = 0;
        if (tc == d) begin
            e.inst = inst; e.cyc = n_acc; e.duty = d;
            done_q.push_back(e);
        end else begin
            while (d != tc) begin
                k++;
                if (tc > d) nd = (d + sc > tc) ? tc : d + sc;
                else        nd = (d - sc < tc) ? tc : d - sc;
                d = nd;
                e.inst = inst;
                e.duty = d;
                e.cyc  = n_acc + k * (r + 1) + ((frz_k > 0 && k > frz_k) ? 7 : 0);
                step_q.push_back(e);
            end
            done_q.push_back(e);
        end
        m_duty[inst] = tc;
        if (inst == 0) begin
            if_a.tgt_valid = 1'b1; if_a.tgt_duty = 8'(t); if_a.tgt_step = 8'(s); if_a.tgt_rate = 16'(r);
        end else begin
            if_b.tgt_valid = 1'b1; if_b.tgt_duty = 8'(t); if_b.tgt_step = 8'(s); if_b.tgt_rate = 16'(r);
        end
        @(negedge clk);
        if_a.tgt_valid = 1'b0;
        if_b.tgt_valid = 1'b0;
    endtask

    task automatic wait_idle(input int inst);
        int n;
        n = 0;
        while (!((inst == 0 ? if_a.tgt_ready : if_b.tgt_ready) &&
                 step_q.size() == 0 && done_q.size() == 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int c);
        int n;
        n = 0;
        while (cyc != c && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("cycle_wait_timeout", cyc, c);
    endtask

    initial begin
        int n_acc;
        int n;
        m_duty[0] = 0; m_duty[1] = 0;
        prev[0]   = 0; prev[1]   = 0;
        if_a.tgt_valid = 1'b0; if_a.tgt_duty = '0; if_a.tgt_step = '0; if_a.tgt_rate = '0;
        if_b.tgt_valid = 1'b0; if_b.tgt_duty = '0; if_b.tgt_step = '0; if_b.tgt_rate = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_duty",  int'(duty_a), 0);
        chk("rst_ready", int'(if_a.tgt_ready), 1);
        chk("rst_busy",  int'(busy_a), 0);
        chk("rst_done",  int'(done_a), 0);
        chk("rst_max_a", int'(max_a), 255);
        chk("rst_max_b", int'(max_b), 200);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Up-ramp 0 -> 100, step 10, every clock.
        send(0, 100, 10, 0, 0, n_acc);
        chk("ramp_busy", int'(busy_a), 1);
        chk("ramp_ready", int'(if_a.tgt_ready), 0);
        wait_idle(0);
        chk("ready_after_up", int'(if_a.tgt_ready), 1);

        // Down-ramp 100 -> 0, step 30, every 4 clocks.
        send(0, 0, 30, 3, 0, n_acc);
        wait_idle(0);
        chk("duty_after_down", int'(duty_a), 0);

        // Clamp to MAX_VALUE = 200.
        send(1, 250, 64, 0, 0, n_acc);
        wait_idle(1);
        chk("duty_clamped", int'(duty_b), 200);

        // Target equal to current duty: done without busy.
        send(0, 0, 5, 0, 0, n_acc);
        chk("equal_busy", int'(busy_a), 0);
        wait_idle(0);

        // Step 0 behaves as step 1.
        send(0, 5, 0, 1, 0, n_acc);
        wait_idle(0);

        // Freeze for 7 clocks after the first step; requests during RAMP ignored.
        send(0, 25, 5, 2, 1, n_acc);
        wait_cyc(n_acc + 3);
        freeze = 1'b1;
        if_a.tgt_valid = 1'b1; if_a.tgt_duty = 8'd200; if_a.tgt_step = 8'd50; if_a.tgt_rate = 16'd0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("ignore_ready", int'(if_a.tgt_ready), 0);
        end
        freeze = 1'b0;
        if_a.tgt_valid = 1'b0;
        wait_idle(0);

        // Back-to-back: new request issued in the done cycle.
        send(0, 60, 20, 0, 0, n_acc);
        n = 0;
        while (!done_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_done_seen", int'(done_a), 1);
        chk("b2b_ready", int'(if_a.tgt_ready), 1);
        send(0, 0, 60, 0, 0, n_acc);
        wait_idle(0);

        // Asynchronous reset mid-ramp.
        send(0, 200, 10, 1, 0, n_acc);
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", int'(busy_a), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_duty",  int'(duty_a), 0);
        chk("midrst_ready", int'(if_a.tgt_ready), 1);
        chk("midrst_busy",  int'(busy_a), 0);
        step_q.delete();
        done_q.delete();
        m_duty[0] = 0;
        m_duty[1] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_duty", int'(duty_a), 0);

        chk("steps_left", step_q.size(), 0);
        chk("dones_left", done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
